clock_divider_32: RTL and testbench



---
 rtl/clock_divider_32_pkg.sv | 6 +
 rtl/clock_divider_32_rise_pulse.sv | 19 +
 rtl/clock_divider_32.sv | 48 ++++
 tb/tb_clock_divider_32.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_32_pkg.sv
// Shared constants for the clock_divider_32 timebase.
package clock_divider_32_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 64;
endpackage

// File: rtl/clock_divider_32_rise_pulse.sv
// One-cycle rising-edge detector over a registered level vector.
module rise_pulse #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] pulse
);
  logic [W-1:0] prev;

  // prev follows level on every edge, so a held level yields a single pulse
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;
endmodule

// File: rtl/clock_divider_32.sv
// Free-running binary divider: counter bank, rising-edge tick bank, and a selectable tap.
module clock_divider_32
  import clock_divider_32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             input_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [SEL_W-1:0] tick_sel,
  output logic [WIDTH-1:0] divided_clocks,
  output logic [WIDTH-1:0] divided_ticks,
  output logic             sel_clock,
  output logic             sel_tick
);
  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("clock_divider_32: WIDTH out of range");
    end
  endgenerate

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge input_clock or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign divided_clocks = cnt;

  rise_pulse #(.W(WIDTH)) u_rise (
    .clock (input_clock),
    .rst_n (reset),
    .level (cnt),
    .pulse (divided_ticks)
  );

  // Non-power-of-two widths leave tick_sel codes with no tap; those read 0
  always_comb begin
    sel_clock = 1'b0;
    sel_tick  = 1'b0;
    if (int'(tick_sel) < WIDTH) begin
      sel_clock = divided_clocks[tick_sel];
      sel_tick  = divided_ticks[tick_sel];
    end
  end
endmodule

// File: tb/tb_clock_divider_32.sv
// Randomized and directed checks of clock_divider_32 against an event-count model.
module tb_clock_divider_32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [4:0] sel32 = '0;
  logic [4:0] sel20 = '0;
  logic [1:0] sel4  = '0;

  logic [31:0] clk32, tck32;
  logic [19:0] clk20, tck20;
  logic [3:0]  clk4,  tck4;
  logic sc32, st32, sc20, st20, sc4, st4;

  int checks = 0;
  int errors = 0;

  // model: number of enabled edges since reset, and whether the last edge counted
  longint unsigned n = 0;
  bit counted = 1'b0;

  always #5 clk = ~clk;

  clock_divider_32 #(.WIDTH(32)) d32 (
    .input_clock(clk), .reset(reset), .enable(enable), .tick_sel(sel32),
    .divided_clocks(clk32), .divided_ticks(tck32), .sel_clock(sc32), .sel_tick(st32));
  clock_divider_32 #(.WIDTH(20)) d20 (
    .input_clock(clk), .reset(reset), .enable(enable), .tick_sel(sel20),
    .divided_clocks(clk20), .divided_ticks(tck20), .sel_clock(sc20), .sel_tick(st20));
  clock_divider_32 #(.WIDTH(4)) d4 (
    .input_clock(clk), .reset(reset), .enable(enable), .tick_sel(sel4),
    .divided_clocks(clk4), .divided_ticks(tck4), .sel_clock(sc4), .sel_tick(st4));

  function automatic logic [63:0] m_cnt(int w);
    return (w == 64) ? n : (n & ((64'd1 << w) - 64'd1));
  endfunction

  // after a counting edge exactly the lowest set bit of the new count has risen
  function automatic logic [63:0] m_tick(int w);
    logic [63:0] c;
    c = m_cnt(w);
    if (!counted) return 64'd0;
    return c & ~(c - 64'd1);
  endfunction

  function automatic logic m_sel(logic [63:0] v, int s, int w);
    return (s < w) ? v[s] : 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!reset) begin n = 0; counted = 1'b0; end
    else begin counted = enable; if (enable) n++; end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    n = 0; counted = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({clk32, tck32, sc32, st32} !== '0) begin
        errors++; $display("FAIL reset_hold: got clk=%h tck=%h sc=%b st=%b want 0", clk32, tck32, sc32, st32);
      end
    end
    reset = 1'b1;
    for (int k = 0; k < 13; k++) step();
    checks++;
    if (clk32 !== 32'd13) begin
      errors++; $display("FAIL pre_reset_count: got %0d want 13", clk32);
    end
    #2 reset = 1'b0;
    #1;
    n = 0; counted = 1'b0;
    checks++;
    if ({clk32, tck32, sc32, st32, clk4, tck4} !== '0) begin
      errors++; $display("FAIL async_reset: got clk=%h tck=%h want 0", clk32, tck32);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_count20();
    do_reset(); enable = 1'b1; sel32 = 5'd0;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (clk32 !== 32'(k)) begin
        errors++; $display("FAIL count20_cnt: got %0d want %0d", clk32, k);
      end
      checks++;
      if (clk32[2] !== 1'((k >> 2) & 1)) begin
        errors++; $display("FAIL count20_bit2 k=%0d: got %b want %b", k, clk32[2], 1'((k >> 2) & 1));
      end
      checks++;
      if (tck32[2] !== (k == 4 || k == 12 || k == 20)) begin
        errors++; $display("FAIL count20_tick2 k=%0d: got %b", k, tck32[2]);
      end
      checks++;
      if (tck32 !== m_tick(32)[31:0]) begin
        errors++; $display("FAIL count20_ticks k=%0d: got %h want %h", k, tck32, m_tick(32)[31:0]);
      end
    end
  endtask

  task automatic test_hold();
    do_reset(); enable = 1'b1;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (clk32 !== 32'd5 || tck32 !== 32'd1) begin
      errors++; $display("FAIL hold_start: got cnt=%0d tck=%h want 5/1", clk32, tck32);
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (clk32 !== 32'd5 || tck32 !== 32'd0) begin
        errors++; $display("FAIL hold_frozen: got cnt=%0d tck=%h want 5/0", clk32, tck32);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (clk32 !== 32'd6 || tck32 !== 32'd2) begin
      errors++; $display("FAIL hold_resume: got cnt=%0d tck=%h want 6/2", clk32, tck32);
    end
  endtask

  task automatic test_wrap();
    do_reset(); enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15) begin
        checks++;
        if (clk4 !== 4'hf) begin errors++; $display("FAIL wrap_15: got %0d want 15", clk4); end
      end
      if (k == 16) begin
        checks++;
        if (clk4 !== 4'h0 || tck4 !== 4'h0) begin
          errors++; $display("FAIL wrap_16: got cnt=%0d tck=%h want 0/0", clk4, tck4);
        end
      end
      if (k == 17) begin
        checks++;
        if (clk4 !== 4'h1 || tck4 !== 4'h1) begin
          errors++; $display("FAIL wrap_17: got cnt=%0d tck=%h want 1/1", clk4, tck4);
        end
      end
    end
  endtask

  task automatic test_sel();
    do_reset(); enable = 1'b1; sel32 = 5'd3;
    for (int k = 1; k <= 30; k++) begin
      step();
      checks++;
      if (st32 !== (k == 8 || k == 24) || sc32 !== 1'((k >> 3) & 1)) begin
        errors++; $display("FAIL sel3 k=%0d: got sc=%b st=%b want %b/%b", k, sc32, st32, 1'((k >> 3) & 1), (k == 8 || k == 24));
      end
    end
  endtask

  task automatic test_sel_switch();
    sel32 = 5'd3;
    step();
    sel32 = 5'd0;
    #1;
    checks++;
    if (sc32 !== m_cnt(32)[0] || st32 !== m_tick(32)[0]) begin
      errors++; $display("FAIL sel_switch: got sc=%b st=%b want %b/%b", sc32, st32, m_cnt(32)[0], m_tick(32)[0]);
    end
  endtask

  task automatic test_sel_oob();
    do_reset(); enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      sel20 = (k % 2 == 0) ? 5'd20 : 5'd31;
      step();
      checks++;
      if (sc20 !== 1'b0 || st20 !== 1'b0 || clk20 !== m_cnt(20)[19:0]) begin
        errors++; $display("FAIL sel_oob sel=%0d: got sc=%b st=%b want 0/0", sel20, sc20, st20);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] e32, t32, e20, t20, e4, t4;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      sel32 = 5'($urandom_range(0, 31));
      sel20 = 5'($urandom_range(0, 31));
      sel4  = 2'($urandom_range(0, 3));
      step();
      e32 = m_cnt(32); t32 = m_tick(32);
      e20 = m_cnt(20); t20 = m_tick(20);
      e4  = m_cnt(4);  t4  = m_tick(4);
      checks++;
      if (clk32 !== e32[31:0] || tck32 !== t32[31:0] ||
          sc32 !== m_sel(e32, int'(sel32), 32) || st32 !== m_sel(t32, int'(sel32), 32)) begin
        errors++; $display("FAIL rand32 k=%0d: got cnt=%h tck=%h sc=%b st=%b want %h/%h", k, clk32, tck32, sc32, st32, e32[31:0], t32[31:0]);
      end
      checks++;
      if (clk20 !== e20[19:0] || tck20 !== t20[19:0] ||
          sc20 !== m_sel(e20, int'(sel20), 20) || st20 !== m_sel(t20, int'(sel20), 20)) begin
        errors++; $display("FAIL rand20 k=%0d: got cnt=%h tck=%h sc=%b st=%b want %h/%h", k, clk20, tck20, sc20, st20, e20[19:0], t20[19:0]);
      end
      checks++;
      if (clk4 !== e4[3:0] || tck4 !== t4[3:0] ||
          sc4 !== m_sel(e4, int'(sel4), 4) || st4 !== m_sel(t4, int'(sel4), 4)) begin
        errors++; $display("FAIL rand4 k=%0d: got cnt=%h tck=%h sc=%b st=%b want %h/%h", k, clk4, tck4, sc4, st4, e4[3:0], t4[3:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count20();
    test_hold();
    test_wrap();
    test_sel();
    test_sel_switch();
    test_sel_oob();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
